// File: rtl/mca_seq_ctrl.sv
// Purpose : sequences one adder-tree conversion per accepted S vector and holds the result for a valid/ready consumer.
// Latency : s_valid -> mca_start 1 cycle; mca_start -> out_valid MCA_LATENCY+1 cycles when the output slot is free.
// Backpr.  : a full, untaken output slot parks the finished conversion in WAIT; s_valid outside IDLE is dropped and flagged.
// Option  : define MCA_SEQ_OVERRUN_CNT_EN to add the 16-bit saturating overrun_cnt output.
module mca_seq_ctrl #(
   parameter int WIDTH_COEFFICIENT = 32,
   parameter int MCA_LATENCY       = 34
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic                                enable,
   input  logic                                s_valid,
   output logic                                s_load,
   output logic                                mca_start,
   input  logic signed [WIDTH_COEFFICIENT-1:0] mca_sample,
   output logic signed [WIDTH_COEFFICIENT-1:0] sample_out,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                busy,
   output logic                                overrun,
`ifdef MCA_SEQ_OVERRUN_CNT_EN
   output logic [15:0]                         overrun_cnt,
`endif
   input  logic                                overrun_clr
);

   // MCA_LATENCY is limited to 2..255, so an 8-bit counter always suffices.
   localparam int         CNT_W = 8;
   localparam logic [7:0] LAT_C = 8'(MCA_LATENCY);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      WAIT  = 2'd3
   } state_e;

   state_e                         state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           out_valid_q, out_valid_d;
   logic [WIDTH_COEFFICIENT-1:0]   sample_q, sample_d;
   logic                           overrun_q, overrun_d;
   logic                           capture;
   logic                           ovr_evt;

   // Any strobe that arrives while a conversion is in flight is lost; remember it.
   assign ovr_evt = s_valid && (state_q != IDLE);

   // Next-state, counter and capture decision; disable wins over everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (s_valid) begin
                  state_d = START;
               end
            end
            START: begin
               // Counter value 1 belongs to the first cycle after the start pulse.
               cnt_d   = 8'd1;
               state_d = RUN;
            end
            RUN: begin
               if (cnt_q == LAT_C) begin
                  // Result is ready; take it now only if the output slot is free or being emptied.
                  if (!out_valid_q || out_ready) begin
                     capture = 1'b1;
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = WAIT;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            WAIT: begin
               // mca_sample is held by the datapath until the next start, so it is still valid here.
               if (out_ready) begin
                  capture = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output slot: a same-cycle capture refills it even while the old value is being taken.
   always_comb begin
      out_valid_d = out_valid_q;
      sample_d    = sample_q;
      if (!enable) begin
         out_valid_d = 1'b0;
      end else if (capture) begin
         out_valid_d = 1'b1;
         sample_d    = mca_sample;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Sticky overrun flag; a new event in the clearing cycle keeps it set.
   always_comb begin
      overrun_d = overrun_q;
      if (ovr_evt) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   // Control state and latency counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Result register and its valid bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_q <= 1'b0;
         sample_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         sample_q    <= sample_d;
      end
   end

   // Overrun flag register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
      end
   end

`ifdef MCA_SEQ_OVERRUN_CNT_EN
   logic [15:0] ovr_cnt_q, ovr_cnt_d;

   // Saturating count of dropped strobes; clear and event together leave a count of one.
   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_clr) begin
         ovr_cnt_d = ovr_evt ? 16'd1 : 16'd0;
      end else if (ovr_evt && (ovr_cnt_q != 16'hFFFF)) begin
         ovr_cnt_d = ovr_cnt_q + 16'd1;
      end
   end

   // Overrun counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovr_cnt_q <= '0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_cnt = ovr_cnt_q;
`endif

   // Load and start are one shared single-cycle strobe decoded from START.
   assign s_load     = (state_q == START);
   assign mca_start  = (state_q == START);
   assign busy       = (state_q != IDLE);
   assign out_valid  = out_valid_q;
   assign sample_out = sample_q;
   assign overrun    = overrun_q;

endmodule
